// File: rtl/multi_matmul_sched.sv
// Job sequencer for a bank of matmul lanes: drives en/reset_acc,
// captures each lane's result on acc_done and drains them in lane order.
module multi_matmul_sched #(
  parameter int OUT_W           = 512,
  parameter int NUM_LANES       = 2,
  parameter int INNER_DIMENSION = 64,
  parameter int BLOCK_SIZE      = 2,
  parameter int TIMEOUT_CYCLES  = 1024,
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_LANES-1:0] lane_mask,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 mm_en,
  output logic                 mm_reset_acc,
  input  logic [NUM_LANES-1:0] mm_acc_done,
  input  logic [NUM_LANES-1:0] mm_systolic_finish,
  input  logic [OUT_W-1:0]     mm_out [NUM_LANES],
  output logic [OUT_W-1:0]     out_data,
  output logic [LW-1:0]        out_lane,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  output logic                 sys_finish_all
);
  localparam int NB = INNER_DIMENSION / BLOCK_SIZE;
  localparam int BW = $clog2(NB + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_WAIT, S_DRAIN, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_LANES-1:0] mask_q, cap_q, cap_d, sf_q, hit;
  logic [OUT_W-1:0]     res_q [NUM_LANES];
  logic [BW-1:0]        beat_q;
  logic [TW-1:0]        to_q;
  logic [LW-1:0]        ptr_q, first_l, next_l, last_l;
  logic                 err_q, launch, capt, all_cap, to_hit;
  logic                 beat_acc, draining, hs;

  assign launch   = (state_q == S_IDLE) && start && (|lane_mask);
  assign capt     = (state_q == S_FEED) || (state_q == S_WAIT);
  assign hit      = capt ? (mm_acc_done & mask_q & ~cap_q) : '0;
  assign cap_d    = cap_q | hit;
  // Include this cycle's captures so WAIT exits without an extra cycle
  assign all_cap  = (cap_d & mask_q) == mask_q;
  assign to_hit   = to_q == TW'(TIMEOUT_CYCLES - 1);
  assign beat_acc = (state_q == S_FEED) && in_valid;
  assign draining = state_q == S_DRAIN;
  assign hs       = draining && out_ready;

  always_comb begin
    first_l = '0;
    next_l  = '0;
    last_l  = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (mask_q[i]) first_l = LW'(i);
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (mask_q[i] && (i > int'(ptr_q))) next_l = LW'(i);
    for (int i = 0; i < NUM_LANES; i++)
      if (mask_q[i]) last_l = LW'(i);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (launch) state_d = S_CLEAR;
      S_CLEAR: state_d = S_FEED;
      S_FEED:
        if (beat_acc && (beat_q == BW'(NB - 1)))
          state_d = S_WAIT;
      S_WAIT:
        if (all_cap)     state_d = S_DRAIN;
        else if (to_hit) state_d = S_DONE;
      S_DRAIN: if (hs && (ptr_q == last_l)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      cap_q   <= '0;
      sf_q    <= '0;
      beat_q  <= '0;
      to_q    <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) res_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        mask_q <= lane_mask;
        err_q  <= 1'b0;
      end
      if (state_q == S_CLEAR) begin
        cap_q  <= '0;
        sf_q   <= '0;
        beat_q <= '0;
        to_q   <= '0;
      end else begin
        cap_q <= cap_d;
        if (state_q != S_IDLE) sf_q <= sf_q | mm_systolic_finish;
        if (beat_acc) beat_q <= beat_q + 1'b1;
        if (state_q == S_WAIT) to_q <= to_q + 1'b1;
      end
      if ((state_q == S_WAIT) && !all_cap && to_hit) err_q <= 1'b1;
      if ((state_q == S_WAIT) && all_cap) ptr_q <= first_l;
      else if (hs)                        ptr_q <= next_l;
      for (int i = 0; i < NUM_LANES; i++)
        if (hit[i]) res_q[i] <= mm_out[i];
    end
  end

  assign in_ready       = state_q == S_FEED;
  assign mm_en          = beat_acc || (state_q == S_WAIT);
  assign mm_reset_acc   = state_q == S_CLEAR;
  assign busy           = (state_q == S_CLEAR) || (state_q == S_FEED) ||
                          (state_q == S_WAIT)  || draining;
  assign done           = state_q == S_DONE;
  assign err_timeout    = err_q;
  assign sys_finish_all = (|mask_q) && (&(sf_q | ~mask_q));
  assign out_valid      = draining;
  assign out_data       = draining ? res_q[ptr_q] : '0;
  assign out_lane       = draining ? ptr_q : '0;
  assign out_last       = draining && (ptr_q == last_l);
endmodule

// File: tb/tb_multi_matmul_sched.sv
// Scoreboard bench for multi_matmul_sched: lane results queued at job
// launch, compared as the drain stream delivers them.
module tb_multi_matmul_sched;
  localparam int W  = 64;
  localparam int NL = 2;
  localparam int NB = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NL-1:0] lane_mask = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, mm_en, mm_reset_acc;
  logic [NL-1:0] acc_done = '0;
  logic [NL-1:0] sys_fin = '0;
  logic [W-1:0]  mm_out [NL];
  logic [W-1:0]  out_data;
  logic          out_lane, out_valid, out_last;
  logic          out_ready = 1'b1;
  logic          busy, done, err_timeout, sys_finish_all;

  multi_matmul_sched #(
    .OUT_W(W), .NUM_LANES(NL), .INNER_DIMENSION(64),
    .BLOCK_SIZE(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .lane_mask(lane_mask),
    .in_valid(in_valid), .in_ready(in_ready), .mm_en(mm_en),
    .mm_reset_acc(mm_reset_acc), .mm_acc_done(acc_done),
    .mm_systolic_finish(sys_fin), .mm_out(mm_out),
    .out_data(out_data), .out_lane(out_lane), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy),
    .done(done), .err_timeout(err_timeout),
    .sys_finish_all(sys_finish_all)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         lane;
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  exp_t sbq[$];
  int   n_err = 0;
  int   n_chk = 0;

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] outs_vec();
    return {in_ready, mm_en, mm_reset_acc, out_valid, out_last, out_lane,
            busy, done, err_timeout, sys_finish_all, |out_data};
  endfunction

  task automatic run_job(input logic [1:0] mask, input bit gaps,
                         input int d0, input int d1, input int stall,
                         input int abort_at, input int exp_wait,
                         input bit exp_to);
    logic [W-1:0] a, b;
    int cyc, beats, lb, ds, done_cyc, nact;
    int en_cnt, rdy_cnt, wait_cnt, clr_cnt, ov_cnt, en_bad;
    bit fin, aborted;
    cyc = 0; beats = 0; lb = -1; ds = -1; done_cyc = -1;
    en_cnt = 0; rdy_cnt = 0; wait_cnt = 0; clr_cnt = 0;
    ov_cnt = 0; en_bad = 0; fin = 0; aborted = 0;
    nact = int'(mask[0]) + int'(mask[1]);
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    @(posedge clk); #1;
    start = 1'b1;
    lane_mask = mask;
    mm_out[0] = ~a;
    mm_out[1] = ~b;
    acc_done = '0;
    sys_fin = '0;
    out_ready = 1'b1;
    in_valid = gaps ? 1'b0 : 1'b1;
    if (abort_at == 0 && !exp_to) begin
      if (mask[0]) sbq.push_back('{1'b0, a, !mask[1]});
      if (mask[1]) sbq.push_back('{1'b1, b, 1'b1});
    end
    for (int k = 0; k < 400 && !fin && !aborted; k++) begin
      @(negedge clk);
      if (cyc == 1) begin
        check("err_clr", W'(err_timeout), 0);
        check("clear_busy", W'(busy), 1);
      end
      en_cnt  += int'(mm_en);
      clr_cnt += int'(mm_reset_acc);
      rdy_cnt += int'(in_ready);
      if (in_ready && (mm_en !== in_valid)) en_bad++;
      if (mm_en && !in_ready) wait_cnt++;
      if (in_ready && in_valid) begin
        beats++;
        if (beats == NB) lb = cyc;
      end
      if (out_valid) begin
        ov_cnt++;
        if (ds < 0) ds = cyc;
        if (sbq.size() == 0) check("unexp_out", 1, 0);
        else begin
          check("out_lane", W'(out_lane), W'(sbq[0].lane));
          check("out_data", out_data, sbq[0].data);
          check("out_last", W'(out_last), W'(sbq[0].last));
          if (out_ready) void'(sbq.pop_front());
        end
      end
      if (done) begin
        fin = 1;
        done_cyc = cyc;
      end
      if (abort_at > 0 && beats == abort_at) begin
        aborted = 1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_outs", W'(outs_vec()), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        acc_done = '0;
        sys_fin = '0;
      end
      if (!fin && !aborted) begin
        @(posedge clk); #1;
        cyc++;
        start = (cyc == 5);
        lane_mask = ~mask;
        if (cyc == 1) acc_done = mask;
        else acc_done = {lb >= 0 && cyc - lb >= d1,
                         lb >= 0 && cyc - lb >= d0};
        sys_fin = (cyc == 1) ? 2'b00 : acc_done;
        if (cyc == 2) begin
          mm_out[0] = a;
          mm_out[1] = b;
        end
        in_valid = gaps ? cyc[0] : 1'b1;
        out_ready = !(ds >= 0 && cyc > ds && cyc <= ds + stall);
      end
    end
    if (aborted) return;
    if (!fin) begin
      check("job_hang", 0, 1);
      return;
    end
    check("en_cnt", W'(en_cnt), W'(NB + exp_wait));
    check("feed_len", W'(rdy_cnt), W'(gaps ? 2 * NB : NB));
    check("wait_len", W'(wait_cnt), W'(exp_wait));
    check("clr_pulse", W'(clr_cnt), 1);
    check("en_mirror", W'(en_bad), 0);
    check("err_done", W'(err_timeout), W'(exp_to));
    check("sys_fin_all", W'(sys_finish_all), W'(!exp_to));
    check("ov_cnt", W'(ov_cnt), W'(exp_to ? 0 : nact + stall));
    check("sb_empty", W'(sbq.size()), 0);
    check("done_cyc", W'(done_cyc),
          W'(2 + (gaps ? 2 * NB : NB) + exp_wait +
             (exp_to ? 0 : nact + stall)));
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
    acc_done = '0;
    out_ready = 1'b1;
    @(negedge clk);
    check("done_pulse", W'({done, busy}), 0);
  endtask

  initial begin
    mm_out[0] = '0;
    mm_out[1] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", W'(outs_vec()), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", W'(outs_vec()), 0);

    @(posedge clk); #1;
    start = 1'b1;
    lane_mask = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_mask", W'({busy, mm_reset_acc, done}), 0);

    run_job(2'b11, 0, 3, 3, 0, 0, 3, 0);
    run_job(2'b11, 1, 3, 3, 0, 0, 3, 0);
    run_job(2'b11, 0, 6, 1, 0, 0, 6, 0);
    run_job(2'b10, 0, 1, 3, 0, 0, 3, 0);
    run_job(2'b11, 0, 3, 3, 4, 0, 3, 0);
    run_job(2'b11, 0, 1, 1000, 0, 0, 8, 1);
    @(negedge clk);
    check("err_sticky", W'(err_timeout), 1);
    run_job(2'b11, 0, 2, 2, 0, 10, 2, 0);
    run_job(2'b11, 0, 2, 2, 0, 0, 2, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
